counter_sched: RTL and testbench
================================

# counter_sched

Round-robin scheduler that shares the mode-controlled step counter (+5 up, −9 down, range −230..235) between an up-requester and a down-requester. Each granted requester owns the counter for a burst of N enabled steps. The scheduler drives the counter's `mode` and `cnt_en`, watches `cnt`, and reports completion. It sits directly in front of the counter; the counter's reset value (−50) and step rules are unchanged.

## Interface
- STEP_UP, 5, counter increment per enabled up step
- STEP_DN, 9, counter decrement magnitude per enabled down step
- CNT_MAX, 235, upper counter bound
- CNT_MIN, −230, lower counter bound
- LEN_W, 4, burst length width (max burst 15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_up  in  1  up-burst request, level, held until gnt_up
- len_up  in  LEN_W  up-burst length, sampled on gnt_up
- req_dn  in  1  down-burst request, level, held until gnt_dn
- len_dn  in  LEN_W  down-burst length, sampled on gnt_dn
- gnt_up  out  1  one-cycle grant pulse to the up-requester
- gnt_dn  out  1  one-cycle grant pulse to the down-requester
- cnt  in  10 signed  current counter value
- cnt_en  out  1  counter step enable
- mode  out  1  1 = up, 0 = down
- busy  out  1  burst in progress (GRANT, RUN or DONE)
- done  out  1  one-cycle pulse at burst end
- abort  out  1  qualifies done: burst cut short by bound check

## Operation
- FSM states: IDLE, GRANT, RUN, DONE. Encoding is in the package.
- IDLE: if any req is high, select the winner via round-robin, then go to GRANT.
  - Both requesting: the winner is the one not granted last. After reset the last-grant pointer favours up.
- GRANT: pulse gnt_x, latch len_x into `remaining`, and set owner.
  - mode = 1 for up, 0 for down. mode is held from GRANT through DONE.
  - If len = 0, go to DONE with abort = 0. Otherwise go to RUN.
- RUN: cnt_en = 1, and `remaining` decrements on each enabled cycle. When `remaining` reaches 1 and that step is taken, go to DONE.
- DONE: done = 1 for one cycle, cnt_en = 0, abort as set. Then IDLE; a new arbitration can start in the next cycle.
- Bound check (when the macro is compiled in):
  - Arithmetic is 11-bit signed.
  - In RUN, up: if cnt + STEP_UP > CNT_MAX, then cnt_en = 0 that cycle, abort = 1, next state DONE.
  - In RUN, down: if cnt − STEP_DN < CNT_MIN, the same response applies.
  - cnt_en is combinational from state and cnt; all other outputs are registered.
- Requests deasserted before grant are simply not served. A request deasserted after grant does not affect the burst.
- Asynchronous reset mid-burst: go to IDLE immediately; the pointer favours up.
- Reset values: gnt_up = gnt_dn = 0, cnt_en = 0, mode = 1, busy = 0, done = 0, abort = 0.

## Timing
- Request sampled in IDLE at cycle T → gnt at T+1 → cnt_en high for T+2..T+1+len → done at T+2+len → IDLE at T+3+len.
- The counter value reflects step k at the edge ending enabled cycle k.
- Minimum gap between consecutive grants: len + 3 cycles. A len = 0 burst takes 3 cycles, from IDLE through done.
- The bound abort takes effect in the same cycle that the violating cnt is observed: no overshoot step occurs.

## Configuration
- COUNTER_SCHED_BOUND_CHECK_EN defined: the bound check is active, and aborts produce done with abort = 1.
- Not defined: bursts always run their full length, and abort is tied to 0. The counter's own range handling then applies.

## Structure
- counter_sched_pkg holds:
  - the state enum;
  - STEP_UP, STEP_DN, CNT_MAX and CNT_MIN defaults;
  - the owner type (OWN_UP / OWN_DN).
- One sub-module: rr_arb2. It is a 2-way round-robin arbiter with a last-grant pointer, updated only on an accepted grant.

## Test plan
- After reset, cnt = −50. req_up with len_up = 4 → gnt_up at T+1, 4 enable cycles, cnt = −45, −40, −35, −30 → done = 1, abort = 0.
- Following that, req_dn with len_dn = 3 from −30 → mode = 0, cnt = −39, −48, −57, then done.
- req_up and req_dn asserted together at reset exit → up granted first, down granted after its done, then up again when both re-request.
- Macro on, cnt = 225, up burst with len = 5 → steps to 230, then 235, then enable drops → done with abort = 1, and cnt stays at 235.
- Macro on, cnt = −222, down burst with len = 2 → no step (−231 < −230) → done with abort = 1.
- rst low during RUN of a len = 10 burst → all outputs 0 and mode = 1 immediately. After release, the next simultaneous request grants up.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter scheduler and its arbiter.
// The bound check in counter_sched is enabled by defining COUNTER_SCHED_BOUND_CHECK_EN.
package counter_sched_pkg;

    localparam int LEN_W   = 4;
    localparam int CNT_W   = 10;
    localparam int EXT_W   = 11;
    localparam int STEP_UP = 5;
    localparam int STEP_DN = 9;
    localparam int CNT_MAX = 235;
    localparam int CNT_MIN = -230;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_DN = 1'b0,
        OWN_UP = 1'b1
    } owner_t;

    // True when the next step in the given direction would leave the counter range.
    function automatic logic bound_hit(input logic signed [CNT_W-1:0] cnt, input logic up);
        logic signed [EXT_W-1:0] x;
        x = EXT_W'(cnt);
        if (up)
            return (x + EXT_W'(STEP_UP)) > EXT_W'(CNT_MAX);
        else
            return (x - EXT_W'(STEP_DN)) < EXT_W'(CNT_MIN);
    endfunction

endpackage

// File: rtl/counter_sched_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is accepted.
// After reset the pointer favours the up requester.
module rr_arb2
    import counter_sched_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_up,
    input  logic i_req_dn,
    input  logic i_accept,
    output logic o_gnt_up,
    output logic o_gnt_dn
);

    logic r_last_up;

    assign o_gnt_up = i_req_up & (~i_req_dn | ~r_last_up);
    assign o_gnt_dn = i_req_dn & (~i_req_up |  r_last_up);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_up <= 1'b0;
        end else if (i_accept && (o_gnt_up || o_gnt_dn)) begin
            r_last_up <= o_gnt_up;
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin burst scheduler in front of the shared up/down step counter.
// Define COUNTER_SCHED_BOUND_CHECK_EN to cut bursts short before the counter leaves its range.
module counter_sched
    import counter_sched_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_up,
    input  logic [LEN_W-1:0]        i_len_up,
    input  logic                    i_req_dn,
    input  logic [LEN_W-1:0]        i_len_dn,
    input  logic signed [CNT_W-1:0] i_cnt,
    output logic                    o_gnt_up,
    output logic                    o_gnt_dn,
    output logic                    o_cnt_en,
    output logic                    o_mode,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_abort
);

    state_t             r_state;
    owner_t             r_owner;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_gnt_up;
    logic               r_gnt_dn;
    logic               r_mode;
    logic               r_busy;
    logic               r_done;
    logic               r_abort;

    logic               w_arb_up;
    logic               w_arb_dn;
    logic               w_idle;
    logic               w_bound_hit;
    logic [LEN_W-1:0]   w_len_sel;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_len_sel = (r_owner == OWN_UP) ? i_len_up : i_len_dn;

    rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req_up (i_req_up),
        .i_req_dn (i_req_dn),
        .i_accept (w_idle),
        .o_gnt_up (w_arb_up),
        .o_gnt_dn (w_arb_dn)
    );

`ifdef COUNTER_SCHED_BOUND_CHECK_EN
    assign w_bound_hit = (r_state == ST_RUN) && bound_hit(i_cnt, r_owner == OWN_UP);
`else
    // Without the bound check the counter value is not needed.
    logic w_cnt_unused;
    assign w_cnt_unused = ^i_cnt;
    assign w_bound_hit  = 1'b0;
`endif

    // Enable is combinational so an out-of-range step is suppressed in the cycle it is seen.
    assign o_cnt_en = (r_state == ST_RUN) && !w_bound_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_UP;
            r_remaining <= '0;
            r_gnt_up    <= 1'b0;
            r_gnt_dn    <= 1'b0;
            r_mode      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_gnt_up <= 1'b0;
            r_gnt_dn <= 1'b0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_up || w_arb_dn) begin
                        r_gnt_up <= w_arb_up;
                        r_gnt_dn <= w_arb_dn;
                        r_owner  <= w_arb_up ? OWN_UP : OWN_DN;
                        r_mode   <= w_arb_up;
                        r_busy   <= 1'b1;
                        r_state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_remaining <= w_len_sel;
                    if (w_len_sel == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_bound_hit) begin
                        r_done  <= 1'b1;
                        r_abort <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt_up = r_gnt_up;
    assign o_gnt_dn = r_gnt_dn;
    assign o_mode   = r_mode;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_abort  = r_abort;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural step counter (+5/-9, clamped to -230..235).
// Bound-check expectations follow COUNTER_SCHED_BOUND_CHECK_EN.
module tb_counter_sched;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_up = 1'b0;
    logic [3:0]        len_up = '0;
    logic              req_dn = 1'b0;
    logic [3:0]        len_dn = '0;
    logic signed [9:0] cnt;
    logic              gnt_up, gnt_dn, cnt_en, mode, busy, done, abort;

    logic              ld = 1'b0;
    logic signed [9:0] ld_val = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_sched dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req_up (req_up),
        .i_len_up (len_up),
        .i_req_dn (req_dn),
        .i_len_dn (len_dn),
        .i_cnt    (cnt),
        .o_gnt_up (gnt_up),
        .o_gnt_dn (gnt_dn),
        .o_cnt_en (cnt_en),
        .o_mode   (mode),
        .o_busy   (busy),
        .o_done   (done),
        .o_abort  (abort)
    );

    function automatic logic signed [9:0] next_cnt(input logic signed [9:0] c, input logic up);
        int n;
        n = up ? int'(c) + 5 : int'(c) - 9;
        if (n > 235)  n = 235;
        if (n < -230) n = -230;
        return 10'(n);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= -10'sd50;
        else if (ld)     cnt <= ld_val;
        else if (cnt_en) cnt <= next_cnt(cnt, mode);
    end

    typedef struct {
        int         ru, lu, rd, ld;
        logic [6:0] flags;  // {gnt_up, gnt_dn, cnt_en, mode, busy, done, abort}
        int         cnt;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(int ru, int lu, int rd, int ld, int gu, int gd, int en,
                                int md, int by, int dn, int ab, int c);
        vec_t v;
        v.ru = ru; v.lu = lu; v.rd = rd; v.ld = ld;
        v.flags = 7'(gu*64 + gd*32 + en*16 + md*8 + by*4 + dn*2 + ab);
        v.cnt = c;
        return v;
    endfunction

    function automatic logic [6:0] flags_now();
        return {gnt_up, gnt_dn, cnt_en, mode, busy, done, abort};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic wait_gnt(input int budget, output int cyc, output logic gu, output logic gd);
        bit seen;
        seen = 1'b0; cyc = 0; gu = 1'b0; gd = 1'b0;
        while (!seen && cyc < budget) begin
            step();
            cyc++;
            if (gnt_up || gnt_dn) begin
                seen = 1'b1; gu = gnt_up; gd = gnt_dn;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_gnt timeout after %0d cycles", budget);
        end
    endtask

    task automatic wait_done(input int budget, output int en_cyc, output logic ab);
        bit seen;
        int n;
        seen = 1'b0; n = 0; en_cyc = 0; ab = 1'b0;
        while (!seen && n < budget) begin
            step();
            n++;
            if (cnt_en) en_cyc++;
            if (done) begin
                seen = 1'b1; ab = abort;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_done timeout after %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   cyc, en_cyc;
        logic gu, gd, ab;

        //              ru lu rd ld  gu gd en md by dn ab  cnt
        vecs[0]  = mk(1, 4, 0, 0,  1, 0, 0, 1, 1, 0, 0, -50);
        vecs[1]  = mk(0, 4, 0, 0,  0, 0, 1, 1, 1, 0, 0, -50);
        vecs[2]  = mk(0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0, -45);
        vecs[3]  = mk(0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0, -40);
        vecs[4]  = mk(0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0, -35);
        vecs[5]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0, -30);
        vecs[6]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, -30);
        vecs[7]  = mk(0, 0, 1, 3,  0, 1, 0, 0, 1, 0, 0, -30);
        vecs[8]  = mk(0, 0, 0, 3,  0, 0, 1, 0, 1, 0, 0, -30);
        vecs[9]  = mk(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, -39);
        vecs[10] = mk(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, -48);
        vecs[11] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, -57);
        vecs[12] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, -57);
        vecs[13] = mk(1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0, -57);
        vecs[14] = mk(0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0, -57);
        vecs[15] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, -57);
        vecs[16] = mk(1, 1, 1, 1,  0, 1, 0, 0, 1, 0, 0, -57);
        vecs[17] = mk(1, 1, 0, 1,  0, 0, 1, 0, 1, 0, 0, -57);
        vecs[18] = mk(1, 1, 0, 0,  0, 0, 0, 0, 1, 1, 0, -66);
        vecs[19] = mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, -66);
        vecs[20] = mk(1, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0, -66);
        vecs[21] = mk(0, 1, 0, 0,  0, 0, 1, 1, 1, 0, 0, -66);
        vecs[22] = mk(0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0, -61);
        vecs[23] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, -61);

        // Reset values
        #12;
        check("reset_flags", int'(flags_now()), int'(7'b0001000));
        check("reset_cnt", int'(cnt), -50);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            req_up = vecs[i].ru[0];
            len_up = 4'(vecs[i].lu);
            req_dn = vecs[i].rd[0];
            len_dn = 4'(vecs[i].ld);
            step();
            checks++;
            if (flags_now() !== vecs[i].flags || int'(cnt) !== vecs[i].cnt) begin
                errors++;
                $display("FAIL vec%0d actual flags=%b cnt=%0d required flags=%b cnt=%0d",
                         i, flags_now(), cnt, vecs[i].flags, vecs[i].cnt);
            end else begin
                $display("vec%0d flags=%b cnt=%0d", i, flags_now(), cnt);
            end
        end

        // Both requesting at reset exit: up, then down, then up again
        req_up = 1'b1; req_dn = 1'b1; len_up = 4'd2; len_dn = 4'd2;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(4, cyc, gu, gd);
        check("rst_exit_grant_up", int'({gu, gd}), 2);
        check("rst_exit_latency", cyc, 1);
        req_up = 1'b0;
        wait_gnt(20, cyc, gu, gd);
        check("second_grant_dn", int'({gu, gd}), 1);
        check("grant_gap_len_plus3", cyc, 5);
        req_dn = 1'b0; req_up = 1'b1;
        wait_done(20, en_cyc, ab);
        check("dn_burst_steps", en_cyc, 2);
        req_dn = 1'b1;
        wait_gnt(4, cyc, gu, gd);
        check("third_grant_up", int'({gu, gd}), 2);
        check("done_to_grant", cyc, 2);
        req_up = 1'b0; req_dn = 1'b0;
        wait_done(20, en_cyc, ab);
        step();

        // Up burst near the upper bound
        ld_val = 10'sd225; ld = 1'b1;
        step();
        ld = 1'b0;
        req_up = 1'b1; len_up = 4'd5;
        wait_gnt(4, cyc, gu, gd);
        check("bound_up_grant", int'({gu, gd}), 2);
        req_up = 1'b0;
        wait_done(20, en_cyc, ab);
`ifdef COUNTER_SCHED_BOUND_CHECK_EN
        check("bound_up_steps", en_cyc, 2);
        check("bound_up_abort", int'(ab), 1);
`else
        check("bound_up_steps", en_cyc, 5);
        check("bound_up_abort", int'(ab), 0);
`endif
        check("bound_up_cnt", int'(cnt), 235);
        step();

        // Down burst near the lower bound
        ld_val = -10'sd222; ld = 1'b1;
        step();
        ld = 1'b0;
        req_dn = 1'b1; len_dn = 4'd2;
        wait_gnt(4, cyc, gu, gd);
        check("bound_dn_grant", int'({gu, gd}), 1);
        req_dn = 1'b0;
        wait_done(20, en_cyc, ab);
`ifdef COUNTER_SCHED_BOUND_CHECK_EN
        check("bound_dn_steps", en_cyc, 0);
        check("bound_dn_abort", int'(ab), 1);
        check("bound_dn_cnt", int'(cnt), -222);
`else
        check("bound_dn_steps", en_cyc, 2);
        check("bound_dn_abort", int'(ab), 0);
        check("bound_dn_cnt", int'(cnt), -230);
`endif
        step();

        // Asynchronous reset in the middle of a long up burst
        req_up = 1'b1; len_up = 4'd10;
        wait_gnt(4, cyc, gu, gd);
        check("long_up_grant", int'({gu, gd}), 2);
        req_up = 1'b0;
        step(); step(); step();
        check("long_up_running", int'(cnt_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_flags", int'(flags_now()), int'(7'b0001000));
        check("midrun_reset_cnt", int'(cnt), -50);
        req_up = 1'b1; req_dn = 1'b1; len_up = 4'd1; len_dn = 4'd1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(4, cyc, gu, gd);
        check("post_reset_grant_up", int'({gu, gd}), 2);
        req_up = 1'b0; req_dn = 1'b0;
        wait_done(10, en_cyc, ab);
        check("post_reset_steps", en_cyc, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
